// File: rtl/pipeline_ctrl_if.sv
// Stall/flush control bundle between the pipeline and its sequencer.
// master = sequencer side, slave = pipeline/hazard-source side.
interface pipeline_ctrl_if;
  logic        load_use_hazard;
  logic        branch_taken_ex;
  logic        mdu_start;
  logic        dmem_ready;
  logic        pc_we;
  logic        if_id_we;
  logic        id_ex_we;
  logic        ex_mem_we;
  logic        mem_wb_we;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        ex_mem_flush;
  logic        redirect;
  logic [1:0]  state_o;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
  logic [31:0] perf_freeze_cnt;

  modport master (
    input  load_use_hazard, branch_taken_ex, mdu_start, dmem_ready,
    output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
    output if_id_flush, id_ex_flush, ex_mem_flush, redirect,
    output state_o, perf_stall_cnt, perf_flush_cnt, perf_freeze_cnt
  );

  modport slave (
    output load_use_hazard, branch_taken_ex, mdu_start, dmem_ready,
    input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
    input  if_id_flush, id_ex_flush, ex_mem_flush, redirect,
    input  state_o, perf_stall_cnt, perf_flush_cnt, perf_freeze_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Optional perf counters: define PIPE_PERF_CNT_EN.
module pipeline_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 4
) (
  input logic            clk,
  input logic            rst_n,
  pipeline_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    RUN = 2'd0,
    LU  = 2'd1,
    MDU = 2'd2,
    ILL = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LD = CNT_W'(MDU_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_1  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [4:0] we_c;
  logic [2:0] fl_c;
  logic       red_c;

  // State and MDU countdown registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and stage controls; we_c={pc,ifid,idex,exmem,memwb}
  always_comb begin
    we_c    = 5'b11111;
    fl_c    = 3'b000;
    red_c   = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!bus.dmem_ready) begin
      we_c = 5'b00000;
    end else begin
      unique case (state_q)
        RUN: begin
          if (bus.branch_taken_ex) begin
            red_c = 1'b1;
            fl_c  = 3'b110;
          end else if (bus.mdu_start) begin
            we_c    = 5'b00011;
            fl_c    = 3'b001;
            cnt_d   = CNT_LD;
            state_d = MDU;
          end else if (bus.load_use_hazard) begin
            we_c    = 5'b00111;
            fl_c    = 3'b010;
            state_d = LU;
          end
        end
        LU: begin
          state_d = RUN;
        end
        MDU: begin
          if (cnt_q > CNT_1) begin
            we_c  = 5'b00011;
            fl_c  = 3'b001;
            cnt_d = cnt_q - CNT_1;
          end else begin
            cnt_d   = '0;
            state_d = RUN;
          end
        end
        ILL: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // Output drive; reset forces every control low
  always_comb begin
    bus.pc_we        = rst_n & we_c[4];
    bus.if_id_we     = rst_n & we_c[3];
    bus.id_ex_we     = rst_n & we_c[2];
    bus.ex_mem_we    = rst_n & we_c[1];
    bus.mem_wb_we    = rst_n & we_c[0];
    bus.if_id_flush  = rst_n & fl_c[2];
    bus.id_ex_flush  = rst_n & fl_c[1];
    bus.ex_mem_flush = rst_n & fl_c[0];
    bus.redirect     = rst_n & red_c;
    bus.state_o      = state_q;
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_q, flush_q, freeze_q;

  // Performance counters, free-running with natural wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q  <= '0;
      flush_q  <= '0;
      freeze_q <= '0;
    end else begin
      if (!we_c[4] && bus.dmem_ready)
        stall_q <= stall_q + 32'd1;
      if (red_c)
        flush_q <= flush_q + 32'd1;
      if (!bus.dmem_ready)
        freeze_q <= freeze_q + 32'd1;
    end
  end

  assign bus.perf_stall_cnt  = stall_q;
  assign bus.perf_flush_cnt  = flush_q;
  assign bus.perf_freeze_cnt = freeze_q;
`else
  assign bus.perf_stall_cnt  = '0;
  assign bus.perf_flush_cnt  = '0;
  assign bus.perf_freeze_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl (MDU_LAT=4).
// Driver queues expected controls; monitor checks at negedge.
module tb_pipeline_ctrl;

  logic clk;
  logic rst_n;

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(.MDU_LAT(4), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] we;
    logic [2:0] fl;
    logic       red;
    logic [1:0] st;
    string      tag;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  localparam logic [4:0] WE_ALL = 5'b11111;
  localparam logic [4:0] WE_NON = 5'b00000;
  localparam logic [4:0] WE_MDU = 5'b00011;
  localparam logic [4:0] WE_LU  = 5'b00111;

  task automatic cyc(
    input logic r, input logic lu, input logic br,
    input logic mdu, input logic rdy,
    input logic [4:0] we, input logic [2:0] fl,
    input logic red, input logic [1:0] st,
    input string tag
  );
    exp_t e;
    @(posedge clk);
    #1;
    rst_n               = r;
    bus.load_use_hazard = lu;
    bus.branch_taken_ex = br;
    bus.mdu_start       = mdu;
    bus.dmem_ready      = rdy;
    e.we  = we;
    e.fl  = fl;
    e.red = red;
    e.st  = st;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic idle(input string tag);
    cyc(1, 0, 0, 0, 1, WE_ALL, 3'b000, 0, 2'd0, tag);
  endtask

  task automatic perf_chk(
    input logic [31:0] s, input logic [31:0] f,
    input logic [31:0] z, input string tag
  );
    logic [31:0] es, ef, ez;
`ifdef PIPE_PERF_CNT_EN
    es = s; ef = f; ez = z;
`else
    es = 0; ef = 0; ez = 0;
`endif
    @(negedge clk);
    checks++;
    if (bus.perf_stall_cnt !== es ||
        bus.perf_flush_cnt !== ef ||
        bus.perf_freeze_cnt !== ez) begin
      errors++;
      $display("FAIL %s: got stall=%0d flush=%0d freeze=%0d want %0d %0d %0d",
               tag, bus.perf_stall_cnt, bus.perf_flush_cnt,
               bus.perf_freeze_cnt, es, ef, ez);
    end
  endtask

  // Monitor: compare one expectation per cycle
  initial begin
    exp_t e;
    logic [10:0] act, want;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        act = {bus.pc_we, bus.if_id_we, bus.id_ex_we,
               bus.ex_mem_we, bus.mem_wb_we,
               bus.if_id_flush, bus.id_ex_flush,
               bus.ex_mem_flush, bus.redirect, bus.state_o};
        want = {e.we, e.fl, e.red, e.st};
        checks++;
        if (act !== want) begin
          errors++;
          $display("FAIL %s: got we/fl/red/st=%b want %b",
                   e.tag, act, want);
        end
      end
    end
  end

  // Driver
  initial begin
    rst_n = 1'b0;
    bus.load_use_hazard = 1'b0;
    bus.branch_taken_ex = 1'b0;
    bus.mdu_start       = 1'b0;
    bus.dmem_ready      = 1'b1;

    cyc(0, 1, 1, 1, 1, WE_NON, 3'b000, 0, 2'd0, "reset_hold");
    cyc(0, 0, 0, 0, 1, WE_NON, 3'b000, 0, 2'd0, "reset_hold2");
    idle("reset_release");
    idle("run_idle");

    cyc(1, 1, 0, 0, 1, WE_LU,  3'b010, 0, 2'd0, "lu_bubble");
    cyc(1, 1, 0, 0, 1, WE_ALL, 3'b000, 0, 2'd1, "lu_advance");
    idle("lu_back_run");

    cyc(1, 0, 0, 1, 1, WE_MDU, 3'b001, 0, 2'd0, "mdu_c0");
    cyc(1, 0, 0, 1, 1, WE_MDU, 3'b001, 0, 2'd2, "mdu_c1");
    cyc(1, 1, 1, 1, 1, WE_MDU, 3'b001, 0, 2'd2, "mdu_c2_ignore");
    cyc(1, 0, 0, 1, 1, WE_ALL, 3'b000, 0, 2'd2, "mdu_c3_adv");
    idle("mdu_back_run");

    cyc(1, 1, 1, 0, 1, WE_ALL, 3'b110, 1, 2'd0, "branch_lu");
    idle("branch_after");
    perf_chk(4, 1, 0, "perf_s234");

    cyc(1, 0, 0, 1, 1, WE_MDU, 3'b001, 0, 2'd0, "frz_mdu_c0");
    cyc(1, 0, 0, 1, 1, WE_MDU, 3'b001, 0, 2'd2, "frz_mdu_c1");
    cyc(1, 0, 0, 1, 0, WE_NON, 3'b000, 0, 2'd2, "frz_0");
    cyc(1, 0, 1, 1, 0, WE_NON, 3'b000, 0, 2'd2, "frz_1");
    cyc(1, 1, 0, 1, 0, WE_NON, 3'b000, 0, 2'd2, "frz_2");
    cyc(1, 0, 0, 1, 1, WE_MDU, 3'b001, 0, 2'd2, "frz_rel_stall");
    cyc(1, 0, 0, 1, 1, WE_ALL, 3'b000, 0, 2'd2, "frz_rel_adv");
    idle("frz_back_run");
    perf_chk(7, 1, 3, "perf_freeze");

    cyc(1, 0, 1, 0, 0, WE_NON, 3'b000, 0, 2'd0, "frz_branch");
    cyc(1, 0, 1, 0, 1, WE_ALL, 3'b110, 1, 2'd0, "branch_after_frz");
    idle("br2_after");

    cyc(1, 0, 0, 1, 1, WE_MDU, 3'b001, 0, 2'd0, "rst_mdu_c0");
    cyc(1, 0, 0, 1, 1, WE_MDU, 3'b001, 0, 2'd2, "rst_mdu_c1");
    cyc(0, 0, 0, 1, 1, WE_NON, 3'b000, 0, 2'd0, "rst_mid_stall");
    cyc(0, 0, 0, 1, 1, WE_NON, 3'b000, 0, 2'd0, "rst_mid_hold");
    idle("rst_mid_release");
    perf_chk(0, 0, 0, "perf_after_rst");
    idle("final_idle");

    for (int i = 0; i < 20 && q.size() > 0; i++)
      @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Consumes `load_use_hazard` from the forwarding unit, the EX-stage branch decision, multi-cycle MDU issue, and data-memory ready.
- Drives write-enable and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB, plus the PC redirect select.
- Guarantees one bubble per load-use hazard and exact MDU occupancy of EX.

Parameters:
- MDU_LAT, 4: cycles a multi-cycle MDU op occupies EX. Legal range is ≥2.
- CNT_W, 4: width of the MDU countdown counter. Must satisfy 2^CNT_W > MDU_LAT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_use_hazard  in  1  ID instruction needs a load result still in EX.
- branch_taken_ex  in  1  EX branch/jump resolved taken.
- mdu_start  in  1  EX holds a multi-cycle MDU op; stays high while the op sits in EX.
- dmem_ready  in  1  MEM access complete; 0 freezes the whole pipeline.
- pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we  out  1 each  stage register load enables.
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load a bubble (NOP, rf_we=0) into that register.
- redirect  out  1  PC selects the branch target this cycle.
- state_o  out  2  current FSM state, for debug.
- perf_stall_cnt, perf_flush_cnt, perf_freeze_cnt  out  32 each  performance counters (see Optional Feature).

Behaviour:
- Reset, while rst_n=0:
  - all *_we=0, all flushes=0, redirect=0.
  - state=RUN(0), cnt=0, perf counters=0.
- All outputs are combinational from state, cnt and inputs. State and cnt are registered.
- States: RUN=0, LU=1, MDU=2. Encoding 3 is illegal and returns to RUN.
- Default (advance) output: all *_we=1, flushes=0, redirect=0.
- Freeze has highest priority in every state. If dmem_ready=0:
  - all *_we=0, flushes=0, redirect=0.
  - state and cnt hold.
  - Pending branch/MDU/hazard is re-evaluated when ready returns, because the EX/ID contents are held.
- RUN, with dmem_ready=1. First match wins:
  1. branch_taken_ex: redirect=1, if_id_flush=1, id_ex_flush=1; stay RUN. The branch kills the ID instruction, so load_use_hazard is ignored.
  2. mdu_start: pc_we=if_id_we=id_ex_we=0, ex_mem_flush=1; cnt<=MDU_LAT-1; next state MDU.
  3. load_use_hazard: pc_we=if_id_we=0, id_ex_flush=1; next state LU.
  4. Otherwise advance.
- LU: advance unconditionally; all hazard inputs ignored; next state RUN. This gives exactly one bubble even if load_use_hazard glitches high.
- MDU:
  - cnt>1: same stall as RUN case 2; cnt<=cnt-1.
  - cnt==1: advance (op result latched into EX/MEM); mdu_start ignored; cnt<=0; next state RUN.
- MDU timing:
  - EX occupancy is exactly MDU_LAT cycles.
  - Front-end stall is MDU_LAT-1 cycles.
  - branch_taken_ex and load_use_hazard are ignored in MDU, since EX holds the MDU op.
- Reset asserted mid-stall: immediate return to the reset values above. No partial bubble survives.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- When defined, the three 32-bit counters increment on non-reset cycles and wrap from 0xFFFF_FFFF to 0:
  - perf_stall_cnt: +1 per cycle with pc_we=0 and dmem_ready=1.
  - perf_flush_cnt: +1 per redirect cycle.
  - perf_freeze_cnt: +1 per dmem_ready=0 cycle.
- When undefined, no counter registers exist and the three ports are tied to 0.

Test Plan:
1. Reset release, all inputs 0, dmem_ready=1 -> all *_we=1, flushes=0, state_o=0 from first edge.
2. load_use_hazard=1 held for 2 cycles -> cycle0: pc_we=0, if_id_we=0, id_ex_flush=1, state_o→1; cycle1: advance, state_o→0. Exactly one bubble.
3. MDU_LAT=4, mdu_start held 4 cycles -> pc_we=0 and ex_mem_flush=1 for 3 cycles; 4th cycle advance; state_o sequence 0,2,2,2,0; no retrigger.
4. branch_taken_ex=1 and load_use_hazard=1 same cycle -> redirect=1, if_id_flush=1, id_ex_flush=1, pc_we=1; state stays 0.
5. dmem_ready=0 for 3 cycles during MDU with cnt=2 -> all *_we=0, cnt holds 2; after release 1 more stall, then advance.
6. PIPE_PERF_CNT_EN defined, run scenarios 2+3+4 -> perf_stall_cnt=4, perf_flush_cnt=1, perf_freeze_cnt=0. Undefined -> all three read 0.
